// File: rtl/msh_rd_rsp_buf_if.sv
// Bundle of request, bank-read and response signals for msh_rd_rsp_buf.
// "slave" is the buffer's view; "master" is the requester/bank side.
interface msh_rd_rsp_buf_if #(
  parameter int NUM_MEM_BANKS = 4,
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 64,
  parameter int TAG_W         = 4,
  parameter int RSP_DEPTH     = 8
) ();
  localparam int BANK_W = $clog2(NUM_MEM_BANKS);
  localparam int CRED_W = $clog2(RSP_DEPTH + 1);

  logic                            rreq_vld;
  logic                            rreq_rdy;
  logic [BANK_W-1:0]               rreq_bank;
  logic [ADDR_W-1:0]               rreq_addr;
  logic [TAG_W-1:0]                rreq_tag;
  logic [NUM_MEM_BANKS-1:0]        mem_rd_en;
  logic [ADDR_W-1:0]               mem_rd_addr;
  logic [NUM_MEM_BANKS*DATA_W-1:0] mem_rd_data;
  logic                            rrsp_vld;
  logic                            rrsp_rdy;
  logic [DATA_W-1:0]               rrsp_data;
  logic [TAG_W-1:0]                rrsp_tag;
  logic [CRED_W-1:0]               rd_credits_used;

  modport slave (
    input  rreq_vld, rreq_bank, rreq_addr, rreq_tag, mem_rd_data, rrsp_rdy,
    output rreq_rdy, mem_rd_en, mem_rd_addr, rrsp_vld, rrsp_data, rrsp_tag,
           rd_credits_used
  );

  modport master (
    output rreq_vld, rreq_bank, rreq_addr, rreq_tag, mem_rd_data, rrsp_rdy,
    input  rreq_rdy, mem_rd_en, mem_rd_addr, rrsp_vld, rrsp_data, rrsp_tag,
           rd_credits_used
  );
endinterface

// File: rtl/msh_rd_rsp_buf.sv
// Mesh read requester/response buffer: strobes the addressed bank, captures its
// fixed-latency data and returns in-order responses under credit flow control.
module msh_rd_rsp_buf #(
  parameter int NUM_MEM_BANKS = 4,
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 64,
  parameter int TAG_W         = 4,
  parameter int MEM_RD_LAT    = 2,
  parameter int RSP_DEPTH     = 8
) (
  input  logic             i_mclk,
  input  logic             i_mrst,
  msh_rd_rsp_buf_if.slave  bus
);
  localparam int BANK_W = $clog2(NUM_MEM_BANKS);
  localparam int CRED_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RSP_DEPTH);
  localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);
  localparam logic [PTR_W:0]    PTR_ONE  = (PTR_W + 1)'(1);

  logic [CRED_W-1:0]        r_cred;
  logic [ADDR_W-1:0]        r_addr;
  logic                     r_pv    [MEM_RD_LAT];
  logic [BANK_W-1:0]        r_pbank [MEM_RD_LAT];
  logic                     r_poor  [MEM_RD_LAT];
  logic [TAG_W-1:0]         r_ptag  [MEM_RD_LAT];
  logic [DATA_W-1:0]        r_fdata [RSP_DEPTH];
  logic [TAG_W-1:0]         r_ftag  [RSP_DEPTH];
  logic [PTR_W:0]           r_wptr;
  logic [PTR_W:0]           r_rptr;

  logic                     w_rdy;
  logic                     w_accept;
  logic                     w_empty;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_oor;
  logic [NUM_MEM_BANKS-1:0] w_en;
  logic [DATA_W-1:0]        w_rdata;

  // Ready depends only on the credit register, never on the response side.
  assign w_rdy    = !i_mrst && (r_cred < CRED_MAX);
  assign w_accept = bus.rreq_vld && w_rdy;
  assign w_empty  = (r_wptr == r_rptr);
  assign w_pop    = !w_empty && bus.rrsp_rdy;
  assign w_push   = r_pv[MEM_RD_LAT-1];

  always_comb begin
    w_oor = 1'b1;
    w_en  = '0;
    for (int b = 0; b < NUM_MEM_BANKS; b++) begin
      if (bus.rreq_bank == BANK_W'(b)) begin
        w_oor   = 1'b0;
        w_en[b] = w_accept;
      end
    end
  end

  // Out-of-range requests select no slice and so return zero data.
  always_comb begin
    w_rdata = '0;
    for (int b = 0; b < NUM_MEM_BANKS; b++) begin
      if (!r_poor[MEM_RD_LAT-1] && (r_pbank[MEM_RD_LAT-1] == BANK_W'(b))) begin
        w_rdata = bus.mem_rd_data[b*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_mclk or posedge i_mrst) begin
    if (i_mrst) begin
      r_cred <= '0;
      r_addr <= '0;
    end else begin
      if (w_accept && !w_pop) begin
        r_cred <= r_cred + CRED_ONE;
      end else if (!w_accept && w_pop) begin
        r_cred <= r_cred - CRED_ONE;
      end
      if (w_accept) begin
        r_addr <= bus.rreq_addr;
      end
    end
  end

  always_ff @(posedge i_mclk or posedge i_mrst) begin
    if (i_mrst) begin
      for (int s = 0; s < MEM_RD_LAT; s++) begin
        r_pv[s]    <= 1'b0;
        r_pbank[s] <= '0;
        r_poor[s]  <= 1'b0;
        r_ptag[s]  <= '0;
      end
    end else begin
      r_pv[0]    <= w_accept;
      r_pbank[0] <= bus.rreq_bank;
      r_poor[0]  <= w_oor;
      r_ptag[0]  <= bus.rreq_tag;
      for (int s = 1; s < MEM_RD_LAT; s++) begin
        r_pv[s]    <= r_pv[s-1];
        r_pbank[s] <= r_pbank[s-1];
        r_poor[s]  <= r_poor[s-1];
        r_ptag[s]  <= r_ptag[s-1];
      end
    end
  end

  // Credits guarantee a free slot whenever the pipeline head pushes.
  always_ff @(posedge i_mclk or posedge i_mrst) begin
    if (i_mrst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_fdata[i] <= '0;
        r_ftag[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_fdata[r_wptr[PTR_W-1:0]] <= w_rdata;
        r_ftag[r_wptr[PTR_W-1:0]]  <= r_ptag[MEM_RD_LAT-1];
        r_wptr                     <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  assign bus.rreq_rdy        = w_rdy;
  assign bus.mem_rd_en       = w_en;
  assign bus.mem_rd_addr     = w_accept ? bus.rreq_addr : r_addr;
  assign bus.rrsp_vld        = !w_empty;
  assign bus.rrsp_data       = r_fdata[r_rptr[PTR_W-1:0]];
  assign bus.rrsp_tag        = r_ftag[r_rptr[PTR_W-1:0]];
  assign bus.rd_credits_used = r_cred;
endmodule
